// File: rtl/rps_match_engine.sv
// Best-of-N stone/paper/scissors match controller: judges one round per start
// edge, tracks scores and counted rounds, and declares a match winner.
module rps_match_engine #(
    parameter int unsigned WIN_TARGET = 3,
    parameter int unsigned SCORE_W    = 3,
    parameter int unsigned MAX_ROUNDS = 9,
    parameter int unsigned RND_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               clear,
    input  logic [1:0]         p1_move,
    input  logic [1:0]         p2_move,
    output logic [1:0]         result,
    output logic               result_valid,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [RND_W-1:0]   round_cnt,
    output logic               match_over,
    output logic [1:0]         match_winner
);

    typedef enum logic {
        READY,
        DONE
    } state_t;

    localparam logic [1:0] RES_TIE     = 2'b00;
    localparam logic [1:0] RES_P1      = 2'b01;
    localparam logic [1:0] RES_P2      = 2'b10;
    localparam logic [1:0] RES_INVALID = 2'b11;

    localparam logic [1:0] MOVE_STONE    = 2'b00;
    localparam logic [1:0] MOVE_PAPER    = 2'b01;
    localparam logic [1:0] MOVE_SCISSORS = 2'b10;
    localparam logic [1:0] MOVE_INVALID  = 2'b11;

    localparam logic [SCORE_W-1:0] WIN_LIMIT = SCORE_W'(WIN_TARGET);
    localparam logic [RND_W-1:0]   RND_LIMIT = RND_W'(MAX_ROUNDS);

    state_t             state, state_nxt;
    logic               start_q;
    logic               trigger;
    logic [1:0]         outcome;
    logic [1:0]         result_nxt;
    logic               result_valid_nxt;
    logic [SCORE_W-1:0] p1_score_nxt, p2_score_nxt;
    logic [RND_W-1:0]   round_cnt_nxt;
    logic [1:0]         match_winner_nxt;

    // start_q tracks start even while disabled so a rising ena never fakes an edge.
    assign trigger    = start & ~start_q & ena;
    assign match_over = (state == DONE);

    always_comb begin
        outcome = RES_P2;
        if (p1_move == MOVE_INVALID || p2_move == MOVE_INVALID) begin
            outcome = RES_INVALID;
        end else if (p1_move == p2_move) begin
            outcome = RES_TIE;
        end else if ((p1_move == MOVE_STONE    && p2_move == MOVE_SCISSORS) ||
                     (p1_move == MOVE_PAPER    && p2_move == MOVE_STONE)    ||
                     (p1_move == MOVE_SCISSORS && p2_move == MOVE_PAPER)) begin
            outcome = RES_P1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= READY;
            start_q      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            p1_score     <= '0;
            p2_score     <= '0;
            round_cnt    <= '0;
            match_winner <= '0;
        end else begin
            state        <= state_nxt;
            start_q      <= start;
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
            p1_score     <= p1_score_nxt;
            p2_score     <= p2_score_nxt;
            round_cnt    <= round_cnt_nxt;
            match_winner <= match_winner_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        result_nxt       = result;
        result_valid_nxt = 1'b0;
        p1_score_nxt     = p1_score;
        p2_score_nxt     = p2_score;
        round_cnt_nxt    = round_cnt;
        match_winner_nxt = match_winner;

        if (ena) begin
            if (clear) begin
                state_nxt        = READY;
                result_nxt       = '0;
                p1_score_nxt     = '0;
                p2_score_nxt     = '0;
                round_cnt_nxt    = '0;
                match_winner_nxt = '0;
            end else if (trigger && state == READY) begin
                result_nxt       = outcome;
                result_valid_nxt = 1'b1;
                unique case (outcome)
                    RES_TIE: round_cnt_nxt = round_cnt + RND_W'(1);
                    RES_P1: begin
                        p1_score_nxt  = p1_score + SCORE_W'(1);
                        round_cnt_nxt = round_cnt + RND_W'(1);
                    end
                    RES_P2: begin
                        p2_score_nxt  = p2_score + SCORE_W'(1);
                        round_cnt_nxt = round_cnt + RND_W'(1);
                    end
                    default: ;
                endcase

                // End-of-match test uses the post-update counts.
                if (outcome != RES_INVALID) begin
                    if (p1_score_nxt == WIN_LIMIT) begin
                        state_nxt        = DONE;
                        match_winner_nxt = RES_P1;
                    end else if (p2_score_nxt == WIN_LIMIT) begin
                        state_nxt        = DONE;
                        match_winner_nxt = RES_P2;
                    end else if (round_cnt_nxt == RND_LIMIT) begin
                        state_nxt = DONE;
                        if (p1_score_nxt > p2_score_nxt) begin
                            match_winner_nxt = RES_P1;
                        end else if (p2_score_nxt > p1_score_nxt) begin
                            match_winner_nxt = RES_P2;
                        end else begin
                            match_winner_nxt = RES_TIE;
                        end
                    end
                end
            end
        end
    end

endmodule
